fetch_ctrl: RTL and testbench

Fetch sequencer feeding `decode`: owns the PC, issues instruction-memory reads, buffers returned words with their PCs in a 2-entry queue, and presents them to `decode` (`pc_i`/`insn_i`) over a valid/ready handshake. Handles back-pressure, halt, and PC redirects (branch/jump resolution) with flush of buffered and in-flight fetches.

---
 rtl/fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_fetch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues instruction-memory reads, buffers returned
// words with their PCs in a 2-entry queue and hands them to decode over valid/ready.
module fetch_ctrl #(
  parameter int unsigned       AWIDTH   = 32,
  parameter int unsigned       DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [AWIDTH-1:0] dec_pc_o,
  output logic [DWIDTH-1:0] dec_insn_o,
  input  logic              halt_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [AWIDTH-1:0] r_pc;
  logic [AWIDTH-1:0] r_req_pc;
  logic              r_inflight;

  logic [AWIDTH-1:0] r_fifo_pc   [2];
  logic [DWIDTH-1:0] r_fifo_insn [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_occ;

  logic [2:0]        w_need;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; redirect does not alter the transitions
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = halt_i ? ST_HALT : ST_RUN;
      ST_RUN:  if (halt_i)  w_state_nxt = ST_HALT;
      ST_HALT: if (!halt_i) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // FSM outputs: handshake, push and issue decisions (issue keeps occ + inflight within 2)
  always_comb begin
    w_need  = 3'(r_occ) + 3'(r_inflight);
    w_valid = (r_occ != 2'd0) && !redirect_i;
    w_pop   = w_valid && dec_ready_i;
    w_push  = r_inflight && !redirect_i;
    w_issue = 1'b0;
    if ((r_state == ST_RUN) && !redirect_i && (w_need < (3'd2 + 3'(w_pop)))) begin
      w_issue = 1'b1;
    end
  end

  // PC, issued-PC and in-flight tracking; redirect kills any outstanding response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else if (redirect_i) begin
      r_pc       <= redirect_pc_i & ~AWIDTH'(3);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc     <= r_pc + AWIDTH'(4);
        r_req_pc <= r_pc;
      end
    end
  end

  // Two-entry response queue; redirect clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_pc[0]   <= '0;
      r_fifo_pc[1]   <= '0;
      r_fifo_insn[0] <= '0;
      r_fifo_insn[1] <= '0;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_occ          <= 2'd0;
    end else if (redirect_i) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]   <= r_req_pc;
        r_fifo_insn[r_wr_ptr] <= imem_rdata_i;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
    end
  end

  assign imem_req_o  = w_issue;
  assign imem_addr_o = r_pc;
  assign dec_valid_o = w_valid;
  assign dec_pc_o    = (r_occ != 2'd0) ? r_fifo_pc[r_rd_ptr]   : '0;
  assign dec_insn_o  = (r_occ != 2'd0) ? r_fifo_insn[r_rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus random traffic checked against
// an in-order PC-stream model (next delivered PC = previous + 4, restarted by redirects).
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_insn;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  fetch_ctrl #(.AWIDTH(32), .DWIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .dec_valid_o  (dec_valid),
    .dec_ready_i  (dec_ready),
    .dec_pc_o     (dec_pc),
    .dec_insn_o   (dec_insn),
    .halt_i       (halt),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a function of address
  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory returns data one cycle after a request, junk otherwise
  logic        m_prev_req;
  logic [31:0] m_prev_addr;
  logic [31:0] m_junk;
  always @(posedge clk) begin
    m_prev_req  <= imem_req;
    m_prev_addr <= imem_addr;
    m_junk      <= $urandom;
  end
  assign imem_rdata = m_prev_req ? f(m_prev_addr) : m_junk;

  task test_reset;
    rst = 1'b1; dec_ready = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RST_PC || dec_valid !== 1'b0 ||
        dec_pc !== 32'h0 || dec_insn !== 32'h0)
      begin errors++; $display("FAIL reset_values: req=%b addr=%h valid=%b pc=%h insn=%h required 0 %h 0 0 0",
                               imem_req, imem_addr, dec_valid, dec_pc, dec_insn, RST_PC); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (c == 0) begin
        if (imem_req !== 1'b0 || dec_valid !== 1'b0)
          begin errors++; $display("FAIL boot_cycle: req=%b valid=%b required 0 0", imem_req, dec_valid); end
      end else if (c < 3) begin
        if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'(4 * (c - 1)) || dec_valid !== 1'b0)
          begin errors++; $display("FAIL first_requests c=%0d: req=%b addr=%h valid=%b required 1 %h 0",
                                   c, imem_req, imem_addr, dec_valid, RST_PC + 32'(4 * (c - 1))); end
      end else begin
        if (dec_valid !== 1'b1 || dec_pc !== RST_PC + 32'(4 * (c - 3)) || dec_insn !== f(RST_PC + 32'(4 * (c - 3))))
          begin errors++; $display("FAIL first_delivery c=%0d: valid=%b pc=%h insn=%h required 1 %h %h",
                                   c, dec_valid, dec_pc, dec_insn, RST_PC + 32'(4 * (c - 3)), f(RST_PC + 32'(4 * (c - 3)))); end
      end
      @(posedge clk); #1;
    end
    exp_pc = RST_PC + 32'd16;
  endtask

  task test_backpressure;
    logic [31:0] hp, hi;
    hp = '0; hi = '0;
    dec_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (s == 0) begin hp = dec_pc; hi = dec_insn; end
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_insn !== f(exp_pc) || imem_req !== 1'b0)
        begin errors++; $display("FAIL stall_hold s=%0d: valid=%b pc=%h insn=%h req=%b required 1 %h %h 0",
                                 s, dec_valid, dec_pc, dec_insn, imem_req, exp_pc, f(exp_pc)); end
      if (s > 0) begin
        checks++;
        if (dec_pc !== hp || dec_insn !== hi)
          begin errors++; $display("FAIL stall_stable s=%0d: pc=%h insn=%h required %h %h", s, dec_pc, dec_insn, hp, hi); end
      end
      @(posedge clk); #1;
    end
    dec_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_insn !== f(exp_pc))
        begin errors++; $display("FAIL stall_release c=%0d: valid=%b pc=%h insn=%h required 1 %h %h",
                                 c, dec_valid, dec_pc, dec_insn, exp_pc, f(exp_pc)); end
      exp_pc += 32'd4;
      @(posedge clk); #1;
    end
  endtask

  task test_redirect;
    dec_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== exp_pc)
      begin errors++; $display("FAIL pre_redirect_head: valid=%b pc=%h required 1 %h", dec_valid, dec_pc, exp_pc); end
    @(posedge clk); #1;
    dec_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_insn !== f(exp_pc))
      begin errors++; $display("FAIL pre_redirect_xfer: valid=%b pc=%h required 1 %h", dec_valid, dec_pc, exp_pc); end
    exp_pc += 32'd4;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h0100_0103;
    @(negedge clk);
    checks++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b0)
      begin errors++; $display("FAIL redirect_cycle: valid=%b req=%b required 0 0", dec_valid, imem_req); end
    @(posedge clk); #1;
    redirect = 1'b0; redirect_pc = '0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (c == 1) begin
        if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0100_0100)
          begin errors++; $display("FAIL redirect_refetch: valid=%b req=%b addr=%h required 0 1 01000100",
                                   dec_valid, imem_req, imem_addr); end
      end else if (c == 2) begin
        if (dec_valid !== 1'b0)
          begin errors++; $display("FAIL redirect_gap: valid=%b required 0", dec_valid); end
        exp_pc = 32'h0100_0100;
      end else begin
        if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_insn !== f(exp_pc))
          begin errors++; $display("FAIL redirect_stream c=%0d: valid=%b pc=%h insn=%h required 1 %h %h",
                                   c, dec_valid, dec_pc, dec_insn, exp_pc, f(exp_pc)); end
        exp_pc += 32'd4;
      end
      @(posedge clk); #1;
    end
  endtask

  task test_halt;
    int n;
    n = 0;
    dec_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      halt = (c < 4);
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        checks++;
        if (imem_req !== 1'b0)
          begin errors++; $display("FAIL halt_no_req c=%0d: req=%b required 0", c, imem_req); end
      end
      if (dec_valid === 1'b1) begin
        checks++;
        if (dec_pc !== exp_pc || dec_insn !== f(exp_pc))
          begin errors++; $display("FAIL halt_stream c=%0d: pc=%h insn=%h required %h %h", c, dec_pc, dec_insn, exp_pc, f(exp_pc)); end
        exp_pc += 32'd4;
        n++;
      end
      @(posedge clk); #1;
    end
    halt = 1'b0;
    checks++;
    if (n != 6)
      begin errors++; $display("FAIL halt_count: transfers=%0d required 6", n); end
  endtask

  task test_wrap;
    logic [31:0] got [3];
    int n;
    n = 0;
    for (int i = 0; i < 3; i++) got[i] = 32'h1;
    dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    checks++;
    if (dec_valid !== 1'b0)
      begin errors++; $display("FAIL wrap_redirect_cycle: valid=%b required 0", dec_valid); end
    exp_pc = 32'hFFFF_FFF8;
    @(posedge clk); #1;
    redirect = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dec_valid === 1'b1) begin
        checks++;
        if (dec_pc !== exp_pc || dec_insn !== f(exp_pc))
          begin errors++; $display("FAIL wrap_stream: pc=%h insn=%h required %h %h", dec_pc, dec_insn, exp_pc, f(exp_pc)); end
        if (n < 3) got[n] = dec_pc;
        n++;
        exp_pc += 32'd4;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n < 3)
      begin errors++; $display("FAIL wrap_count: transfers=%0d required >=3", n); end
    checks++;
    if (got[0] !== 32'hFFFF_FFF8 || got[1] !== 32'hFFFF_FFFC || got[2] !== 32'h0000_0000)
      begin errors++; $display("FAIL wrap_pcs: %h %h %h required fffffff8 fffffffc 00000000", got[0], got[1], got[2]); end
  endtask

  task test_random;
    int          halt_cnt, n;
    logic        p_halt, p_stall;
    logic [31:0] p_pc, p_insn, tgt;
    halt_cnt = 0; p_halt = 1'b0; p_stall = 1'b0; p_pc = '0; p_insn = '0; n = 0;
    for (int c = 0; c < 400; c++) begin
      dec_ready = ($urandom_range(0, 9) < 7);
      redirect  = ($urandom_range(0, 24) == 0);
      tgt = ($urandom_range(0, 1) == 1) ? $urandom : (RST_PC + 32'($urandom_range(0, 255)));
      redirect_pc = tgt;
      if (halt_cnt > 0) begin halt = 1'b1; halt_cnt--; end
      else begin halt = 1'b0; if ($urandom_range(0, 19) == 0) halt_cnt = $urandom_range(1, 5); end
      @(negedge clk);
      if (redirect) begin
        checks++;
        if (dec_valid !== 1'b0)
          begin errors++; $display("FAIL rnd_redirect_valid c=%0d: valid=%b required 0", c, dec_valid); end
      end
      if (p_halt) begin
        checks++;
        if (imem_req !== 1'b0)
          begin errors++; $display("FAIL rnd_halt_req c=%0d: req=%b required 0", c, imem_req); end
      end
      if (p_stall && !redirect) begin
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== p_pc || dec_insn !== p_insn)
          begin errors++; $display("FAIL rnd_stall_stable c=%0d: valid=%b pc=%h insn=%h required 1 %h %h",
                                   c, dec_valid, dec_pc, dec_insn, p_pc, p_insn); end
      end
      if (dec_valid === 1'b1 && dec_ready) begin
        checks++;
        if (dec_pc !== exp_pc || dec_insn !== f(exp_pc))
          begin errors++; $display("FAIL rnd_stream c=%0d: pc=%h insn=%h required %h %h", c, dec_pc, dec_insn, exp_pc, f(exp_pc)); end
        exp_pc += 32'd4;
      end
      if (redirect) exp_pc = tgt & ~32'd3;
      p_halt  = halt;
      p_stall = (dec_valid === 1'b1) && !dec_ready && !redirect;
      p_pc    = dec_pc;
      p_insn  = dec_insn;
      @(posedge clk); #1;
    end
    halt = 1'b0; redirect = 1'b0; dec_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dec_valid === 1'b1) begin
        checks++;
        if (dec_pc !== exp_pc || dec_insn !== f(exp_pc))
          begin errors++; $display("FAIL rnd_drain: pc=%h insn=%h required %h %h", dec_pc, dec_insn, exp_pc, f(exp_pc)); end
        exp_pc += 32'd4;
        n++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n < 10)
      begin errors++; $display("FAIL rnd_progress: transfers=%0d in 20 cycles required >=10", n); end
  endtask

  task test_async_reset;
    dec_ready = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RST_PC || dec_valid !== 1'b0 ||
        dec_pc !== 32'h0 || dec_insn !== 32'h0)
      begin errors++; $display("FAIL async_reset: req=%b addr=%h valid=%b pc=%h insn=%h required 0 %h 0 0 0",
                               imem_req, imem_addr, dec_valid, dec_pc, dec_insn, RST_PC); end
    test_reset();
  endtask

  initial begin
    rst = 1'b1; dec_ready = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; exp_pc = RST_PC;
    test_reset();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
